uart_rx_mmio: RTL



---
 rtl/uart_rx_mmio.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with RX_DATA (read pops) and RX_STAT (W1C flags) registers.
// Define UART_RX_FIFO_EN to get a FIFO_DEPTH-entry circular buffer instead of a single holding register.
`ifndef UART_DIV
`define UART_DIV 16
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef IO_UART_RX_OFFSET
`define IO_UART_RX_OFFSET 32'h0000_0010
`endif
`ifndef IO_UART_RX_STAT_OFFSET
`define IO_UART_RX_STAT_OFFSET 32'h0000_0014
`endif

module uart_rx_mmio #(
  parameter int UART_DIV   = `UART_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mmio_req,
  input  logic               mmio_we,
  input  logic [`ADDR_W-1:0] mmio_addr,
  input  logic [`XLEN-1:0]   mmio_wdata,
  output logic [`XLEN-1:0]   mmio_rdata,
  output logic               mmio_ready,
  input  logic               uart_rx
);

  localparam int AW = `ADDR_W;
  localparam int XW = `XLEN;
  localparam logic [AW-1:0] RxDataAddr = AW'(`IO_BASE_ADDR + `IO_UART_RX_OFFSET);
  localparam logic [AW-1:0] RxStatAddr = AW'(`IO_BASE_ADDR + `IO_UART_RX_STAT_OFFSET);
  localparam logic [15:0]   HalfDiv    = 16'(UART_DIV / 2 - 1);
  localparam logic [15:0]   FullDiv    = 16'(UART_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rxSync_q;
  logic [15:0] divCnt_q, divCnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  shift_q, shift_d;
  logic        overrun_q, overrun_d;
  logic        frameErr_q, frameErr_d;

  logic       rxS;
  logic       push, frameSet, pop, pushOk;
  logic       dataRead, statWrite;
  logic       empty, full;
  logic [7:0] head;
  logic       unusedWdata;

  assign rxS         = rxSync_q[1];
  assign unusedWdata = ^{mmio_wdata[XW-1:3], mmio_wdata[0]};

  assign dataRead  = mmio_req && !mmio_we && (mmio_addr == RxDataAddr);
  assign statWrite = mmio_req &&  mmio_we && (mmio_addr == RxStatAddr);
  assign pop       = dataRead && !empty;
  // A pop on the same edge frees the slot, so a push into a full buffer still succeeds.
  assign pushOk    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rxSync_q   <= 2'b11;
      divCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxSync_q   <= {rxSync_q[0], uart_rx};
      divCnt_q   <= divCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    divCnt_d = divCnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    frameSet = 1'b0;
    if (divCnt_q != 16'd0) begin
      divCnt_d = divCnt_q - 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (!rxS) begin
          state_d  = START;
          divCnt_d = HalfDiv;
        end
      end
      START: begin
        if (divCnt_q == 16'd0) begin
          if (!rxS) begin
            state_d  = DATA;
            divCnt_d = FullDiv;
            bitIdx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (divCnt_q == 16'd0) begin
          shift_d  = {rxS, shift_q[7:1]};
          divCnt_d = FullDiv;
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (divCnt_q == 16'd0) begin
          push     = rxS;
          frameSet = !rxS;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag updates: the clear is applied first so a same-cycle error event wins.
  always_comb begin
    overrun_d  = overrun_q;
    frameErr_d = frameErr_q;
    if (statWrite && mmio_wdata[1]) overrun_d = 1'b0;
    if (statWrite && mmio_wdata[2]) frameErr_d = 1'b0;
    if (push && !pushOk) overrun_d = 1'b1;
    if (frameSet) frameErr_d = 1'b1;
  end

`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[PW-1] != rdPtr_q[PW-1]) && (wrPtr_q[PW-2:0] == rdPtr_q[PW-2:0]);
  assign head  = mem_q[rdPtr_q[PW-2:0]];

  always_comb begin
    wrPtr_d = wrPtr_q + PW'(pushOk);
    rdPtr_d = rdPtr_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q[PW-2:0]] <= shift_q;
    end
  end
`else
  localparam int unusedDepth = FIFO_DEPTH;

  logic [7:0] hold_q, hold_d;
  logic       holdVld_q, holdVld_d;

  assign empty = !holdVld_q;
  assign full  = holdVld_q;
  assign head  = hold_q;

  always_comb begin
    hold_d    = pushOk ? shift_q : hold_q;
    holdVld_d = holdVld_q;
    if (pop)    holdVld_d = 1'b0;
    if (pushOk) holdVld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      holdVld_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      holdVld_q <= holdVld_d;
    end
  end
`endif

  always_comb begin
    mmio_rdata = '0;
    if (mmio_req && !mmio_we) begin
      if (mmio_addr == RxDataAddr && !empty) begin
        mmio_rdata = XW'(head);
      end else if (mmio_addr == RxStatAddr) begin
        mmio_rdata = XW'({frameErr_q, overrun_q, !empty});
      end
    end
  end

  assign mmio_ready = mmio_req;

endmodule
